// File: rtl/uart_fifo_cmd_sched.sv
// uart_fifo_cmd_sched: decodes one-byte commands from the UART RX stream and
// sequences FIFO reads into UART TX starts.
// Commands: 0x01 SEND_ALL, 0x02 SEND_N (next byte is N), 0x03 FLUSH, 0x04 STATUS.
// Optional feature macro: SCHED_ABORT_EN. When it is defined, a 0x00 byte
// received mid-transfer stops the loop at the next FETCH. When it is not
// defined, that byte is dropped with an err pulse like any other.
// Handshake: rx_valid is a one-cycle strobe with no backpressure, so every byte
// is consumed in the cycle it arrives. fifo_rd_en, fifo_clr and tx_start are
// one-cycle strobes, and tx_busy is this block's only flow control.
module uart_fifo_cmd_sched #(
    parameter int CNT_W       = 8,
    parameter int ARG_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             fifo_empty,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic [7:0]       fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             fifo_clr,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARG   = 3'd1,
        FETCH = 3'd2,
        CAPT  = 3'd3,
        LOAD  = 3'd4,
        HOLD  = 3'd5,
        TXW   = 3'd6,
        CLR   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        M_ALL  = 2'd0,
        M_N    = 2'd1,
        M_STAT = 2'd2
    } mode_t;

    localparam int TO_W = $clog2(ARG_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ARG_TIMEOUT - 1);

    state_t          state;
    mode_t           mode;
    logic [7:0]      remaining;
    logic [TO_W-1:0] arg_cnt;
    logic [7:0]      count_lo;
    logic            abort_q;
    logic            abort_hit;
    logic            drop_err;

    assign count_lo  = fifo_count[7:0];
    assign busy      = (state != IDLE);
    assign dbg_state = state;

`ifdef SCHED_ABORT_EN
    logic in_xfer;
    assign in_xfer   = (state == FETCH) || (state == CAPT) || (state == LOAD) ||
                       (state == HOLD) || (state == TXW);
    assign abort_hit = in_xfer && rx_valid && (rx_data == 8'h00);

    // Latch a mid-transfer 0x00 so the loop stops at the next FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n)
            abort_q <= 1'b0;
        else if (state == IDLE)
            abort_q <= 1'b0;
        else if (abort_hit)
            abort_q <= 1'b1;
    end
`else
    assign abort_hit = 1'b0;
    assign abort_q   = 1'b0;
`endif

    // A byte that arrives while a command is running is dropped and flagged.
    assign drop_err = rx_valid && (state != IDLE) && (state != ARG) && !abort_hit;

    // Command FSM: all strobes and tx_data are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode       <= M_ALL;
            remaining  <= 8'h00;
            arg_cnt    <= '0;
            tx_data    <= 8'h00;
            fifo_rd_en <= 1'b0;
            fifo_clr   <= 1'b0;
            tx_start   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            fifo_clr   <= 1'b0;
            tx_start   <= 1'b0;
            done       <= 1'b0;
            err        <= drop_err;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            8'h01: begin
                                mode       <= M_ALL;
                                state      <= FETCH;
                                fifo_rd_en <= !fifo_empty;
                            end
                            8'h02: begin
                                mode    <= M_N;
                                arg_cnt <= '0;
                                state   <= ARG;
                            end
                            8'h03: begin
                                fifo_clr <= 1'b1;
                                done     <= 1'b1;
                                state    <= CLR;
                            end
                            8'h04: begin
                                mode  <= M_STAT;
                                state <= CAPT;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ARG: begin
                    if (rx_valid) begin
                        remaining <= rx_data;
                        if (rx_data == 8'h00) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            fifo_rd_en <= !fifo_empty;
                            state      <= FETCH;
                        end
                    end else if (arg_cnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        arg_cnt <= arg_cnt + TO_W'(1);
                    end
                end
                FETCH: begin
                    // The read decision was taken on entry; fifo_rd_en records it.
                    if (fifo_rd_en) begin
                        state <= CAPT;
                    end else begin
                        done  <= 1'b1;
                        err   <= drop_err || abort_q || (mode == M_N);
                        state <= IDLE;
                    end
                end
                CAPT: begin
                    tx_data  <= (mode == M_STAT) ? count_lo : fifo_rd_data;
                    tx_start <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    if ((mode == M_N) && (remaining != 8'h00))
                        remaining <= remaining - 8'd1;
                    state <= HOLD;
                end
                HOLD: state <= TXW;
                TXW: begin
                    if (!tx_busy) begin
                        if ((mode == M_STAT) || ((mode == M_N) && (remaining == 8'h00))) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            fifo_rd_en <= !fifo_empty && !abort_q && !abort_hit;
                            state      <= FETCH;
                        end
                    end
                end
                CLR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_fifo_cmd_sched.md
# uart_fifo_cmd_sched

Command sequencer between the UART receiver, the byte FIFO and the UART transmitter. Decodes one-byte commands arriving on the RX stream, then sequences FIFO reads into UART TX starts (drain-all, send-N), clears the FIFO, or reports FIFO occupancy. It is the single owner of `fifo_rd_en`, `fifo_clr` and `tx_start`.

## Interface
- `CNT_W`, 8, width of `fifo_count`; only bits [7:0] are reported by STATUS.
- `ARG_TIMEOUT`, 1000, cycles to wait for the SEND_N argument byte before abandoning the command.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `fifo_empty`  in  1  FIFO has no data.
- `fifo_count`  in  CNT_W  FIFO occupancy.
- `fifo_rd_data`  in  8  read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  one-cycle read strobe.
- `fifo_clr`  out  1  one-cycle FIFO clear strobe.
- `tx_data`  out  8  byte to transmit, registered, stable from `tx_start` until `tx_busy` falls.
- `tx_start`  out  1  one-cycle transmit strobe.
- `tx_busy`  in  1  TX active; rises the cycle after `tx_start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  one-cycle pulse on any error.

## Operation
- Commands, decoded in IDLE on `rx_valid`:
  - 0x01 SEND_ALL: transmit FIFO bytes until `fifo_empty`.
  - 0x02 SEND_N: the next byte is N; transmit N bytes.
  - 0x03 FLUSH: pulse `fifo_clr`.
  - 0x04 STATUS: transmit `fifo_count[7:0]`.
  - Any other value: `err` pulse, stay IDLE.
- States:
  - IDLE: waits for a command byte.
  - ARG: waits for the SEND_N argument.
  - FETCH: `fifo_rd_en`=1 if not empty.
  - CAPT: `tx_data` <= `fifo_rd_data`.
  - LOAD: `tx_start`=1.
  - HOLD: one cycle.
  - TXW: waits for `tx_busy`=0.
  - CLR: `fifo_clr`=1, `done`=1.
- Transfer loop: FETCH→CAPT→LOAD→HOLD→TXW→FETCH.
  - From TXW, go to IDLE with `done` when the remaining count reaches 0 (SEND_N), or when `fifo_empty` is sampled in FETCH.
- SEND_N ending early: if FETCH sees `fifo_empty` with remaining>0, pulse `done` and `err` together and go to IDLE.
- SEND_N with N=0: `done` pulse, no FIFO read.
- SEND_ALL on an empty FIFO: `done` only, no `err`.
- ARG timeout: `ARG_TIMEOUT` cycles without `rx_valid` → `err`, go to IDLE.
- STATUS: load `tx_data` with `fifo_count[7:0]` in CAPT, skip FETCH; after TXW go to IDLE with `done`.
- `rx_valid` outside IDLE/ARG: byte dropped, `err` pulse, state unchanged (see Configuration).
- Remaining-count register is 8 bits and decrements in LOAD; it never wraps below 0.
- `fifo_rd_en` and `tx_start` are never high in the same cycle.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE; `fifo_rd_en`, `fifo_clr`, `tx_start`, `busy`, `done`, `err` = 0; `tx_data`=0x00; counters cleared.
- Reset mid-transfer: no further strobes after the reset edge. A UART byte already in flight is not cancelled.
- SEND_ALL latency, with command strobe sampled at edge t:
  - FETCH / `fifo_rd_en` in cycle t+1.
  - CAPT in t+2.
  - `tx_start` in t+3.
  - HOLD in t+4.
  - TXW from t+5.
- Per-byte period: 4 cycles plus the `tx_busy` high time.
- FLUSH: `fifo_clr` and `done` in cycle t+1.
- STATUS: `tx_start` in cycle t+2.
- `fifo_count` is sampled in CAPT.

## Configuration
- `SCHED_ABORT_EN` defined: byte 0x00 received during FETCH..TXW sets an abort flag (no `err`).
  - The current byte finishes.
  - At the next FETCH the block goes to IDLE with `done`+`err` and issues no read.
- `SCHED_ABORT_EN` undefined: 0x00 mid-transfer is treated like any other dropped byte (`err` pulse only) and the transfer runs to completion.

## Test plan
- FIFO holds 0xA1,0xB2,0xC3; send 0x01 → three `tx_start`s with `tx_data` 0xA1,0xB2,0xC3 in order; `done` once; exactly 3 `fifo_rd_en`.
- FIFO holds 5 bytes; send 0x02,0x02 → 2 bytes transmitted, `done` without `err`, `fifo_count` ends at 3.
- FIFO holds 1 byte; send 0x02,0x04 → 1 byte transmitted, then `done`+`err` in the same cycle.
- `fifo_count`=0x17; send 0x04 → `tx_start` 2 cycles after the strobe with `tx_data`=0x17. Send 0x03 → `fifo_clr` and `done` one cycle after the strobe.
- Send 0x02, then idle for `ARG_TIMEOUT` cycles → `err` pulse, `busy`=0, no FIFO read. Separately, send 0x7F → `err` only.
- Send 0x01 on a 4-byte FIFO; assert `rst_n`=0 during the second TXW → all outputs 0 at the next edge, no further `fifo_rd_en`. With `SCHED_ABORT_EN` defined, sending 0x00 during byte 2 stops after byte 2 with `done`+`err`.
